// File: rtl/stim_source.sv
`default_nettype none
// stim_source: streams a table of stimulus words upstream of a DUT over valid/ready,
// with optional idle gaps (none, fixed, LFSR-random) and a sticky completion flag.
module stim_source #(
    parameter int          D_WIDTH     = 16,
    parameter int          START_DELAY = 4,
    parameter int          GAP_MODE    = 0,
    parameter int          GAP_CYCLES  = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    // Word table, word0 in the least significant slice (converted from the hex vector file)
    parameter int          NUM_WORDS   = 3,
    parameter logic [((NUM_WORDS > 0) ? NUM_WORDS : 1)*D_WIDTH-1:0] WORDS = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [D_WIDTH-1:0] data_o,
    output logic [31:0]        sent_cnt_o,
    output logic               done_o
);

    localparam int            IW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'((NUM_WORDS > 0) ? NUM_WORDS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q;
    logic [31:0]   cnt_q;
    logic [IW-1:0] idx_q;
    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_d;
    logic [31:0]   gap_d;

    function automatic logic [D_WIDTH-1:0] word_at(input logic [IW-1:0] i);
        return WORDS[int'(i)*D_WIDTH +: D_WIDTH];
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11; free-running so gaps replay identically from reset
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        gap_d = '0;
        if (GAP_MODE == 1) begin
            gap_d = 32'(GAP_CYCLES);
        end else if (GAP_MODE == 2) begin
            gap_d = {30'd0, lfsr_q[1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
            sent_cnt_o <= '0;
            done_o     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_q <= '0;
                        if (NUM_WORDS == 0) begin
                            state_q <= S_DONE;
                            done_o  <= 1'b1;
                        end else if (START_DELAY == 0) begin
                            state_q <= S_SEND;
                            valid_o <= 1'b1;
                            data_o  <= word_at('0);
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 32'(START_DELAY);
                        end
                    end
                end
                // Both countdowns present the word at idx_q on the edge the count expires
                S_WAIT, S_GAP: begin
                    if (cnt_q <= 32'd1) begin
                        state_q <= S_SEND;
                        cnt_q   <= '0;
                        valid_o <= 1'b1;
                        data_o  <= word_at(idx_q);
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                S_SEND: begin
                    if (ready_i) begin
                        sent_cnt_o <= sent_cnt_o + 32'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                            valid_o <= 1'b0;
                            data_o  <= '0;
                            done_o  <= 1'b1;
                        end else if (gap_d != 32'd0) begin
                            state_q <= S_GAP;
                            valid_o <= 1'b0;
                            cnt_q   <= gap_d;
                            idx_q   <= idx_q + 1'b1;
                        end else begin
                            data_o <= word_at(idx_q + 1'b1);
                            idx_q  <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stim_source.sv
`default_nettype none
// tb_stim_source: directed checks of stim_source in back-to-back, fixed-gap,
// empty-table and random-gap configurations.
module tb_stim_source;

    localparam int NR = 100;

    function automatic logic [NR*16-1:0] build_rnd();
        logic [NR*16-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*16 +: 16] = 16'(i + 1);
        return r;
    endfunction

    localparam logic [NR*16-1:0] RND_WORDS = build_rnd();

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_r;
    logic [3:0]  ready_r;
    logic [3:0]  valid_w;
    logic [3:0]  done_w;
    logic [15:0] data_w [4];
    logic [31:0] sent_w [4];

    int total;
    int bad;

    logic [15:0] m_lfsr;
    bit          vtrace [2][600];

    stim_source #(.D_WIDTH(16), .START_DELAY(4), .GAP_MODE(0), .GAP_CYCLES(2),
                  .LFSR_SEED(16'hACE1), .NUM_WORDS(3), .WORDS(48'h0003_0002_0001)) u_b2b (
        .clk(clk), .rst_n(rst_n), .start_i(start_r[0]), .ready_i(ready_r[0]),
        .valid_o(valid_w[0]), .data_o(data_w[0]), .sent_cnt_o(sent_w[0]), .done_o(done_w[0]));

    stim_source #(.D_WIDTH(16), .START_DELAY(4), .GAP_MODE(1), .GAP_CYCLES(2),
                  .LFSR_SEED(16'hACE1), .NUM_WORDS(3), .WORDS(48'h0003_0002_0001)) u_gap (
        .clk(clk), .rst_n(rst_n), .start_i(start_r[1]), .ready_i(ready_r[1]),
        .valid_o(valid_w[1]), .data_o(data_w[1]), .sent_cnt_o(sent_w[1]), .done_o(done_w[1]));

    stim_source #(.D_WIDTH(16), .START_DELAY(4), .GAP_MODE(0), .GAP_CYCLES(2),
                  .LFSR_SEED(16'hACE1), .NUM_WORDS(0), .WORDS(16'h0000)) u_empty (
        .clk(clk), .rst_n(rst_n), .start_i(start_r[2]), .ready_i(ready_r[2]),
        .valid_o(valid_w[2]), .data_o(data_w[2]), .sent_cnt_o(sent_w[2]), .done_o(done_w[2]));

    stim_source #(.D_WIDTH(16), .START_DELAY(4), .GAP_MODE(2), .GAP_CYCLES(2),
                  .LFSR_SEED(16'hACE1), .NUM_WORDS(NR), .WORDS(RND_WORDS)) u_rnd (
        .clk(clk), .rst_n(rst_n), .start_i(start_r[3]), .ready_i(ready_r[3]),
        .valid_o(valid_w[3]), .data_o(data_w[3]), .sent_cnt_o(sent_w[3]), .done_o(done_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gap LFSR: x^16+x^14+x^13+x^11, shifting every clock out of reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start_r[n] = 1'b1;
        @(negedge clk);
        start_r[n] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (valid_w[n] !== 1'b0 || done_w[n] !== 1'b0 || data_w[n] !== 16'h0 || sent_w[n] !== 32'h0) begin
                bad++;
                $display("FAIL reset inst%0d: valid=%b done=%b data=%h sent=%0d, want all zero",
                         n, valid_w[n], done_w[n], data_w[n], sent_w[n]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic        ev;
        logic        edn;
        logic [15:0] ed;
        logic [31:0] es;
        do_reset();
        ready_r[0] = 1'b1;
        pulse_start(0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            ev  = (k >= 4 && k <= 6);
            ed  = 16'(k - 3);
            es  = (k < 5) ? 32'd0 : ((k >= 7) ? 32'd3 : 32'(k - 4));
            edn = (k >= 7);
            total++;
            if (valid_w[0] !== ev || done_w[0] !== edn || sent_w[0] !== es) begin
                bad++;
                $display("FAIL basic T+%0d: valid=%b done=%b sent=%0d, want valid=%b done=%b sent=%0d",
                         k, valid_w[0], done_w[0], sent_w[0], ev, edn, es);
            end
            if (ev) begin
                total++;
                if (data_w[0] !== ed) begin
                    bad++;
                    $display("FAIL basic_data T+%0d: data=%h want %h", k, data_w[0], ed);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_r[0] = 1'b1;
        pulse_start(0);
        repeat (5) @(negedge clk);
        total++;
        if (valid_w[0] !== 1'b1 || data_w[0] !== 16'h0002 || sent_w[0] !== 32'd1) begin
            bad++;
            $display("FAIL bp_pre: valid=%b data=%h sent=%0d, want 1 0002 1", valid_w[0], data_w[0], sent_w[0]);
        end
        ready_r[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (valid_w[0] !== 1'b1 || data_w[0] !== 16'h0002 || sent_w[0] !== 32'd1) begin
                bad++;
                $display("FAIL bp_hold %0d: valid=%b data=%h sent=%0d, want 1 0002 1",
                         i, valid_w[0], data_w[0], sent_w[0]);
            end
        end
        ready_r[0] = 1'b1;
        @(negedge clk);
        total++;
        if (valid_w[0] !== 1'b1 || data_w[0] !== 16'h0003 || sent_w[0] !== 32'd2) begin
            bad++;
            $display("FAIL bp_resume: valid=%b data=%h sent=%0d, want 1 0003 2", valid_w[0], data_w[0], sent_w[0]);
        end
        @(negedge clk);
        total++;
        if (valid_w[0] !== 1'b0 || done_w[0] !== 1'b1 || sent_w[0] !== 32'd3) begin
            bad++;
            $display("FAIL bp_done: valid=%b done=%b sent=%0d, want 0 1 3", valid_w[0], done_w[0], sent_w[0]);
        end
        // start_i in DONE must not restart the stream
        pulse_start(0);
        repeat (5) @(negedge clk);
        total++;
        if (valid_w[0] !== 1'b0 || done_w[0] !== 1'b1 || sent_w[0] !== 32'd3) begin
            bad++;
            $display("FAIL done_sticky: valid=%b done=%b sent=%0d, want 0 1 3", valid_w[0], done_w[0], sent_w[0]);
        end
    endtask

    task automatic test_fixed_gap();
        logic        ev;
        logic        edn;
        logic [15:0] ed;
        logic [31:0] es;
        do_reset();
        ready_r[1] = 1'b1;
        pulse_start(1);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            ev  = (k == 4 || k == 7 || k == 10);
            ed  = 16'((k - 1) / 3);
            es  = (k < 5) ? 32'd0 : (k < 8) ? 32'd1 : (k < 11) ? 32'd2 : 32'd3;
            edn = (k >= 11);
            total++;
            if (valid_w[1] !== ev || done_w[1] !== edn || sent_w[1] !== es) begin
                bad++;
                $display("FAIL gap T+%0d: valid=%b done=%b sent=%0d, want valid=%b done=%b sent=%0d",
                         k, valid_w[1], done_w[1], sent_w[1], ev, edn, es);
            end
            if (ev) begin
                total++;
                if (data_w[1] !== ed) begin
                    bad++;
                    $display("FAIL gap_data T+%0d: data=%h want %h", k, data_w[1], ed);
                end
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        ready_r[2] = 1'b1;
        total++;
        if (done_w[2] !== 1'b0) begin
            bad++;
            $display("FAIL empty_pre: done=%b want 0", done_w[2]);
        end
        pulse_start(2);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (done_w[2] !== 1'b1 || valid_w[2] !== 1'b0 || sent_w[2] !== 32'd0) begin
                bad++;
                $display("FAIL empty T+%0d: done=%b valid=%b sent=%0d, want 1 0 0",
                         k, done_w[2], valid_w[2], sent_w[2]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        ready_r[0] = 1'b1;
        pulse_start(0);
        repeat (6) @(negedge clk);
        total++;
        if (sent_w[0] !== 32'd2 || data_w[0] !== 16'h0003) begin
            bad++;
            $display("FAIL mid_pre: sent=%0d data=%h, want 2 0003", sent_w[0], data_w[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (valid_w[0] !== 1'b0 || data_w[0] !== 16'h0 || sent_w[0] !== 32'd0 || done_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: valid=%b data=%h sent=%0d done=%b, want all zero",
                     valid_w[0], data_w[0], sent_w[0], done_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start(0);
        repeat (4) @(negedge clk);
        total++;
        if (valid_w[0] !== 1'b1 || data_w[0] !== 16'h0001) begin
            bad++;
            $display("FAIL mid_restart: valid=%b data=%h, want 1 0001", valid_w[0], data_w[0]);
        end
        @(negedge clk);
        total++;
        if (data_w[0] !== 16'h0002 || sent_w[0] !== 32'd1) begin
            bad++;
            $display("FAIL mid_second: data=%h sent=%0d, want 0002 1", data_w[0], sent_w[0]);
        end
    endtask

    task automatic test_random(input int run);
        int  low;
        int  gexp;
        int  nxt;
        bit  pend;
        int  gap_bad;
        int  data_bad;
        for (int c = 0; c < 600; c++) vtrace[run][c] = 1'b0;
        do_reset();
        ready_r[3] = 1'b1;
        pulse_start(3);
        nxt = 1; pend = 0; low = 0; gexp = 0; gap_bad = 0; data_bad = 0;
        for (int c = 0; c < 600 && done_w[3] !== 1'b1; c++) begin
            vtrace[run][c] = valid_w[3];
            if (valid_w[3] === 1'b1) begin
                if (data_w[3] !== 16'(nxt)) begin
                    data_bad++;
                    if (data_bad == 1) $display("FAIL rnd%0d_data: data=%h want %h", run, data_w[3], 16'(nxt));
                end
                if (pend && (low !== gexp || low > 3)) begin
                    gap_bad++;
                    if (gap_bad == 1) $display("FAIL rnd%0d_gap word %0d: gap=%0d want %0d", run, nxt, low, gexp);
                end
                gexp = int'(m_lfsr[1:0]);
                pend = 1;
                low  = 0;
                nxt++;
            end else if (pend) begin
                low++;
            end
            @(negedge clk);
        end
        total++;
        if (data_bad != 0) bad++;
        total++;
        if (gap_bad != 0) bad++;
        total++;
        if (done_w[3] !== 1'b1 || sent_w[3] !== 32'(NR) || nxt != NR + 1) begin
            bad++;
            $display("FAIL rnd%0d_end: done=%b sent=%0d words_seen=%0d, want 1 %0d %0d",
                     run, done_w[3], sent_w[3], nxt - 1, NR, NR);
        end
    endtask

    task automatic test_random_repeat();
        int diffs;
        test_random(0);
        test_random(1);
        diffs = 0;
        for (int c = 0; c < 600; c++) if (vtrace[0][c] != vtrace[1][c]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL rnd_repeat: %0d differing valid cycles, want 0", diffs);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        start_r = '0;
        ready_r = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_fixed_gap();
        test_empty();
        test_midstream_reset();
        test_random_repeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/stim_source.md
Name: stim_source

Overview:
- Testbench stimulus generator. Reads a hex vector file and streams the words into the DUT input over a valid/ready handshake.
- Sits directly upstream of the DUT. The file-based result checker sits downstream of the DUT, so a file pair (stimulus, expected) fully describes a test.
- Supports programmable idle gaps (none, fixed, pseudo-random) so the DUT is exercised under bubbles. Flags completion for end-of-test control.

Parameters:
- FILENAME, " ", path of stimulus file: one hex word per whitespace-separated token.
- D_WIDTH, 16, data width in bits.
- START_DELAY, 4, cycles between start acceptance and first valid_o.
- GAP_MODE, 0, 0 = back-to-back, 1 = fixed gap, 2 = LFSR random gap.
- GAP_CYCLES, 2, idle cycles after each handshake in GAP_MODE 1 (0 is legal and means no gap).
- LFSR_SEED, 16'hACE1, reset value of the gap LFSR (must be non-zero).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start_i  input  1  begin streaming; sampled only in IDLE
- ready_i  input  1  DUT accepts data_o this cycle
- valid_o  output  1  data_o holds a valid word
- data_o  output  D_WIDTH  current stimulus word
- sent_cnt_o  output  32  number of completed handshakes
- done_o  output  1  all file words delivered; sticky

Behaviour:
- Reset (async assert, any state):
  - valid_o=0, data_o=0, sent_cnt_o=0, done_o=0; state=IDLE; LFSR=LFSR_SEED.
  - Word queue is cleared and the file is re-read in file order.
  - If the file fails to open: print the filename and $finish.
  - Print the word count read.
- All outputs are registered and update only on posedge clk.
- FSM states: IDLE, WAIT, SEND, GAP, DONE.
- IDLE:
  - start_i=1 at a posedge with an empty queue -> DONE (done_o=1 on that edge).
  - start_i=1 otherwise -> WAIT, with delay counter loaded to START_DELAY.
  - If START_DELAY=0, go directly to SEND: valid_o=1 and data_o=word0 on the same edge.
- WAIT: counter decrements each edge. On the edge where it reaches 0 -> SEND, with valid_o=1 and data_o=head word.
- SEND:
  - valid_o=1. data_o must stay stable while ready_i=0; valid_o never drops without a handshake.
  - Handshake = valid_o & ready_i at a posedge. On handshake: pop head, sent_cnt_o+1. Then:
    - Last word -> DONE: valid_o=0, data_o=0, done_o=1 on the same edge.
    - Gap length g>0 -> GAP: valid_o=0, counter=g.
    - g=0 -> stay in SEND with data_o=next word. Back-to-back gives one word per cycle.
- GAP: valid_o=0. Counter decrements each edge; after exactly g cycles with valid low -> SEND presenting the next word. ready_i is ignored.
- Gap length g:
  - GAP_MODE 0: g=0.
  - GAP_MODE 1: g=GAP_CYCLES.
  - GAP_MODE 2: g=LFSR[1:0], range 0..3.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clock out of reset regardless of state, so the sequence is reproducible from reset.
- DONE: holds until reset; start_i and ready_i are ignored. Print the completion message exactly once with $time.
- start_i outside IDLE: ignored.
- Reset mid-stream: abort, restart from word0 after the next start_i. No partial state is retained.
- sent_cnt_o wraps at 2^32 (no saturation).

Test Plan:
- Basic stream: file {0001,0002,0003}, GAP_MODE 0, START_DELAY 4, ready_i=1, start_i pulsed at edge T.
  - valid_o rises at T+4; data_o = 0001, 0002, 0003 on consecutive cycles.
  - done_o=1 and valid_o=0 at T+7; sent_cnt_o=3.
- Backpressure: same file, ready_i=0 for 5 cycles while 0002 is presented.
  - valid_o stays 1, data_o holds 0002, sent_cnt_o holds 1.
  - 0003 appears on the cycle after ready_i returns to 1.
- Fixed gap: GAP_MODE 1, GAP_CYCLES 2, ready_i=1.
  - Exactly 2 cycles of valid_o=0 between handshakes; no gap after the last word.
  - done_o at T+START_DELAY+2*3+... i.e. 3 handshakes plus 4 gap cycles after first valid.
- Empty file plus start_i: done_o=1 on the sampling edge; valid_o never asserts; sent_cnt_o=0.
- Mid-stream reset: assert rst_n low after 2 handshakes.
  - All outputs are 0 immediately (async).
  - After release and start_i, data_o again sequences from 0001.
- Random gap plus loopback: GAP_MODE 2, seed 16'hACE1, DUT replaced by a wire into the checker, 100-word file.
  - Zero mismatches reported.
  - All gaps fall in 0..3.
  - Two runs give identical valid_o waveforms.
